// File: rtl/m68k_region_decoder.sv
// Table-driven 68000 region decoder: one-hot selects, DTACK after per-region waits, BERR on timeout.
// Latency: selects 1 edge after the strobe sample, DTACK W edges later. Holds outputs until the CPU drops AS.
// Optional macro DECODER_OVERLAP_CHECK_EN builds the sticky multi_hit overlap detector.
module m68k_region_decoder #(
    parameter int NUM_REGIONS = 24,
    parameter int ADDR_W      = 24,
    parameter int WAIT_W      = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [4:0]             cfg_idx,
    input  logic [ADDR_W-1:0]      cfg_base,
    input  logic [4:0]             cfg_width,
    input  logic [WAIT_W-1:0]      cfg_wait,
    input  logic                   cfg_en,
    input  logic [ADDR_W-1:0]      cpu_a,
    input  logic                   cpu_as_n,
    output logic [NUM_REGIONS-1:0] region_cs,
    output logic [4:0]             hit_idx,
    output logic                   dtack_n,
    output logic                   berr_n,
    output logic                   multi_hit
);

    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int CNT_W = (WAIT_W > TO_W) ? WAIT_W : TO_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_MISS} state_t;

    logic [ADDR_W-1:0] base_r  [NUM_REGIONS];
    logic [4:0]        width_r [NUM_REGIONS];
    logic [WAIT_W-1:0] wait_r  [NUM_REGIONS];
    logic              en_r    [NUM_REGIONS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_r[i]  <= '0;
                width_r[i] <= '0;
                wait_r[i]  <= '0;
                en_r[i]    <= 1'b0;
            end
        end else if (cfg_we && (32'(cfg_idx) < NUM_REGIONS)) begin
            base_r[cfg_idx]  <= cfg_base;
            width_r[cfg_idx] <= cfg_width;
            wait_r[cfg_idx]  <= cfg_wait;
            en_r[cfg_idx]    <= cfg_en;
        end
    end

    // Decode against the table as it stands at the sampling edge, so a
    // same-edge table write cannot affect the cycle being sampled.
    logic [NUM_REGIONS-1:0] match;
    logic [ADDR_W-1:0]      mask;

    always_comb begin
        match = '0;
        mask  = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            mask = (32'(width_r[i]) >= ADDR_W) ? '0 : ({ADDR_W{1'b1}} << width_r[i]);
            match[i] = en_r[i] && ((cpu_a & mask) == (base_r[i] & mask));
        end
    end

    logic              dec_hit;
    logic [4:0]        dec_idx;
    logic [WAIT_W-1:0] dec_wait;

    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = '0;
        dec_wait = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (match[i]) begin
                dec_hit  = 1'b1;
                dec_idx  = 5'(i);
                dec_wait = wait_r[i];
            end
        end
    end

    logic              as_q;
    logic              hit_q;
    logic [4:0]        idx_q;
    logic [WAIT_W-1:0] wait_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            as_q   <= 1'b1;
            hit_q  <= 1'b0;
            idx_q  <= '0;
            wait_q <= '0;
        end else begin
            as_q   <= cpu_as_n;
            hit_q  <= dec_hit;
            idx_q  <= dec_idx;
            wait_q <= dec_wait;
        end
    end

`ifdef DECODER_OVERLAP_CHECK_EN
    logic multi_q;
    logic multi_r;
    logic multi_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            multi_q <= 1'b0;
            multi_r <= 1'b0;
        end else begin
            multi_q <= |(match & (match - NUM_REGIONS'(1)));
            multi_r <= multi_nxt;
        end
    end

    assign multi_hit = multi_r;
`else
    assign multi_hit = 1'b0;
`endif

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [NUM_REGIONS-1:0] cs_nxt;
    logic [4:0]             idx_nxt;
    logic                   dtack_nxt;
    logic                   berr_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            region_cs <= '0;
            hit_idx   <= '0;
            dtack_n   <= 1'b1;
            berr_n    <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            region_cs <= cs_nxt;
            hit_idx   <= idx_nxt;
            dtack_n   <= dtack_nxt;
            berr_n    <= berr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cs_nxt    = region_cs;
        idx_nxt   = hit_idx;
        dtack_nxt = dtack_n;
        berr_nxt  = berr_n;
`ifdef DECODER_OVERLAP_CHECK_EN
        multi_nxt = multi_r;
`endif
        if (state == S_IDLE) begin
            if (!as_q) begin
`ifdef DECODER_OVERLAP_CHECK_EN
                multi_nxt = multi_r | multi_q;
`endif
                if (hit_q) begin
                    cs_nxt  = NUM_REGIONS'(1) << idx_q;
                    idx_nxt = idx_q;
                    cnt_nxt = CNT_W'(wait_q);
                    if (wait_q == '0) begin
                        state_nxt = S_ACK;
                        dtack_nxt = 1'b0;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end else begin
                    state_nxt = S_MISS;
                    cnt_nxt   = '0;
                end
            end
        end else if (as_q) begin
            // Strobe released: abandon whatever phase we are in.
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            cs_nxt    = '0;
            idx_nxt   = '0;
            dtack_nxt = 1'b1;
            berr_nxt  = 1'b1;
        end else begin
            case (state)
                S_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = S_ACK;
                        dtack_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                S_MISS: begin
                    // berr_n low marks the terminal hold inside MISS.
                    if (berr_n) begin
                        if (cnt == CNT_W'(TIMEOUT - 2)) begin
                            berr_nxt = 1'b0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Directed bench for m68k_region_decoder with a timeline-based reference model checked every cycle.
module tb_m68k_region_decoder;

    localparam int NR  = 24;
    localparam int AW  = 24;
    localparam int WW  = 4;
    localparam int TO  = 64;
    localparam int INF = 1 << 30;
`ifdef DECODER_OVERLAP_CHECK_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          cfg_we;
    logic [4:0]    cfg_idx;
    logic [AW-1:0] cfg_base;
    logic [4:0]    cfg_width;
    logic [WW-1:0] cfg_wait;
    logic          cfg_en;
    logic [AW-1:0] cpu_a;
    logic          cpu_as_n;
    logic [NR-1:0] region_cs;
    logic [4:0]    hit_idx;
    logic          dtack_n;
    logic          berr_n;
    logic          multi_hit;

    m68k_region_decoder #(
        .NUM_REGIONS(NR), .ADDR_W(AW), .WAIT_W(WW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base),
        .cfg_width(cfg_width), .cfg_wait(cfg_wait), .cfg_en(cfg_en),
        .cpu_a(cpu_a), .cpu_as_n(cpu_as_n),
        .region_cs(region_cs), .hit_idx(hit_idx), .dtack_n(dtack_n),
        .berr_n(berr_n), .multi_hit(multi_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (after edge %0d)", name, got, exp, edge_n);
        end
    endtask

    // Reference model: one bus cycle described by its sample edge, release edge and decode result.
    logic [AW-1:0] m_base [NR];
    int            m_width[NR];
    int            m_wait [NR];
    bit            m_en   [NR];
    bit            m_act;
    bit            m_hit;
    int            m_t, m_r, m_idx, m_w;
    int            m_mh = INF;

    function automatic bit covers(input int i, input logic [AW-1:0] a);
        if (!m_en[i]) return 1'b0;
        if (m_width[i] >= AW) return 1'b1;
        return (a >> m_width[i]) == (m_base[i] >> m_width[i]);
    endfunction

    always @(posedge clk) begin
        int hits;
        edge_n++;
        if (reset) begin
            m_act = 1'b0;
            m_mh  = INF;
            for (int i = 0; i < NR; i++) begin
                m_base[i] = '0; m_width[i] = 0; m_wait[i] = 0; m_en[i] = 1'b0;
            end
        end else begin
            if (m_act && m_r == INF && cpu_as_n) m_r = edge_n;
            else if (m_act && m_r != INF && edge_n > m_r) m_act = 1'b0;
            if (!m_act && !cpu_as_n) begin
                hits  = 0;
                m_hit = 1'b0;
                for (int i = 0; i < NR; i++) begin
                    if (covers(i, cpu_a)) begin
                        if (!m_hit) begin
                            m_hit = 1'b1; m_idx = i; m_w = m_wait[i];
                        end
                        hits++;
                    end
                end
                m_act = 1'b1;
                m_t   = edge_n;
                m_r   = INF;
                if (hits >= 2 && m_mh == INF) m_mh = edge_n + 1;
            end
            if (cfg_we && cfg_idx < NR) begin
                m_base[cfg_idx]  = cfg_base;
                m_width[cfg_idx] = cfg_width;
                m_wait[cfg_idx]  = cfg_wait;
                m_en[cfg_idx]    = cfg_en;
            end
        end
    end

    always @(negedge clk) begin
        logic [NR-1:0] e_cs;
        logic [4:0]    e_idx;
        logic          e_dt, e_be, e_mh;
        if (edge_n > 0) begin
            e_cs = '0; e_idx = '0; e_dt = 1'b1; e_be = 1'b1;
            if (m_act && edge_n >= m_t + 1 && (m_r == INF || edge_n <= m_r)) begin
                if (m_hit) begin
                    e_cs  = NR'(1) << m_idx;
                    e_idx = 5'(m_idx);
                    if (edge_n >= m_t + 1 + m_w) e_dt = 1'b0;
                end else if (edge_n >= m_t + TO) begin
                    e_be = 1'b0;
                end
            end
            e_mh = OVL && (edge_n >= m_mh);
            check("model_cs",    32'(region_cs), 32'(e_cs));
            check("model_idx",   32'(hit_idx),   32'(e_idx));
            check("model_dtack", 32'(dtack_n),   32'(e_dt));
            check("model_berr",  32'(berr_n),    32'(e_be));
            check("model_multi", 32'(multi_hit), 32'(e_mh));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input int idx, input logic [AW-1:0] base, input int w,
                             input int wt, input bit en);
        cfg_we    = 1'b1;
        cfg_idx   = 5'(idx);
        cfg_base  = base;
        cfg_width = 5'(w);
        cfg_wait  = WW'(wt);
        cfg_en    = en;
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic strobe(input logic [AW-1:0] a);
        cpu_a    = a;
        cpu_as_n = 1'b0;
    endtask

    task automatic release_as();
        cpu_as_n = 1'b1;
        tick(2);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_width = '0;
        cfg_wait = '0; cfg_en = 1'b0; cpu_a = '0; cpu_as_n = 1'b1;
        tick(3);
        check("rst_cs",    32'(region_cs), 32'h0);
        check("rst_idx",   32'(hit_idx),   32'h0);
        check("rst_dtack", 32'(dtack_n),   32'h1);
        check("rst_berr",  32'(berr_n),    32'h1);
        check("rst_multi", 32'(multi_hit), 32'h0);
        reset = 1'b0;
        tick(1);

        // Empty table: timeout bus error.
        strobe(24'h123456);
        tick(64);
        check("miss_berr_t63", 32'(berr_n), 32'h1);
        tick(1);
        check("miss_berr_t64", 32'(berr_n), 32'h0);
        check("miss_cs",       32'(region_cs), 32'h0);
        cpu_as_n = 1'b1;
        tick(1);
        check("miss_berr_r", 32'(berr_n), 32'h0);
        tick(1);
        check("miss_berr_r1", 32'(berr_n), 32'h1);

        // Zero-wait region.
        cfg_write(0, 24'h000000, 18, 0, 1'b1);
        strobe(24'h001234);
        tick(1);
        check("z_cs_t0", 32'(region_cs), 32'h0);
        tick(1);
        check("z_cs_t1",    32'(region_cs), 32'h000001);
        check("z_dtack_t1", 32'(dtack_n),   32'h0);
        tick(2);
        cpu_as_n = 1'b1;
        tick(1);
        check("z_cs_r", 32'(region_cs), 32'h000001);
        tick(1);
        check("z_cs_r1",    32'(region_cs), 32'h0);
        check("z_dtack_r1", 32'(dtack_n),   32'h1);

        // Three wait states.
        cfg_write(3, 24'h400000, 1, 3, 1'b1);
        strobe(24'h400000);
        tick(2);
        check("w3_cs_t1",    32'(region_cs), 32'h000008);
        check("w3_idx_t1",   32'(hit_idx),   32'd3);
        check("w3_dtack_t1", 32'(dtack_n),   32'h1);
        tick(2);
        check("w3_dtack_t3", 32'(dtack_n), 32'h1);
        tick(1);
        check("w3_dtack_t4", 32'(dtack_n), 32'h0);
        release_as();

        // Overlapping entries: lowest index wins.
        cfg_write(2, 24'h080000, 16, 1, 1'b1);
        cfg_write(5, 24'h000000, 20, 0, 1'b1);
        strobe(24'h080000);
        tick(2);
        check("ovl_cs",    32'(region_cs), 32'h000004);
        check("ovl_multi", 32'(multi_hit), 32'(OVL));
        tick(1);
        check("ovl_dtack", 32'(dtack_n), 32'h0);
        release_as();

        // Abort during wait states, then a normal cycle.
        cfg_write(7, 24'hA00000, 4, 7, 1'b1);
        strobe(24'hA00005);
        tick(3);
        cpu_as_n = 1'b1;
        tick(1);
        check("ab_cs_t3",    32'(region_cs), 32'h000080);
        check("ab_dtack_t3", 32'(dtack_n),   32'h1);
        tick(1);
        check("ab_cs_t4", 32'(region_cs), 32'h0);
        strobe(24'hA00005);
        tick(2);
        check("ab2_cs_t1", 32'(region_cs), 32'h000080);
        tick(6);
        check("ab2_dtack_t7", 32'(dtack_n), 32'h1);
        tick(1);
        check("ab2_dtack_t8", 32'(dtack_n), 32'h0);
        release_as();

        // Same-edge table write and strobe decode with the old (disabled) entry.
        cfg_we = 1'b1; cfg_idx = 5'd9; cfg_base = 24'h600000; cfg_width = 5'd8;
        cfg_wait = '0; cfg_en = 1'b1;
        strobe(24'h600010);
        tick(1);
        cfg_we = 1'b0;
        tick(1);
        check("sim_cs_old", 32'(region_cs), 32'h0);
        release_as();
        strobe(24'h600010);
        tick(2);
        check("sim_cs_new",    32'(region_cs), 32'h000200);
        check("sim_dtack_new", 32'(dtack_n),   32'h0);
        release_as();

        // Reset while in wait states drops the cycle and clears the table.
        strobe(24'hA00005);
        tick(3);
        reset = 1'b1; cpu_as_n = 1'b1;
        tick(1);
        check("rw_cs",    32'(region_cs), 32'h0);
        check("rw_idx",   32'(hit_idx),   32'h0);
        check("rw_dtack", 32'(dtack_n),   32'h1);
        check("rw_berr",  32'(berr_n),    32'h1);
        check("rw_multi", 32'(multi_hit), 32'h0);
        reset = 1'b0;
        cfg_write(30, 24'hA00000, 4, 0, 1'b1);
        strobe(24'hA00005);
        tick(64);
        check("rw_berr_t63", 32'(berr_n), 32'h1);
        tick(1);
        check("rw_berr_t64", 32'(berr_n),    32'h0);
        check("rw_cs_miss",  32'(region_cs), 32'h0);
        release_as();

        // Width beyond the address bus matches everything.
        cfg_write(1, 24'h123456, 31, 2, 1'b1);
        strobe(24'hFFFFFE);
        tick(2);
        check("wide_cs",  32'(region_cs), 32'h000002);
        check("wide_idx", 32'(hit_idx),   32'd1);
        tick(2);
        check("wide_dtack", 32'(dtack_n), 32'h0);
        release_as();

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m68k_region_decoder.md
# m68k_region_decoder

Table-driven, registered 68000 address decoder and bus-cycle controller for the Toaplan-style cores. It generates one-hot chip selects, DTACK and bus error for each 68000 bus cycle. The fixed per-PCB memory maps become a runtime-loadable region table: base, match width, wait states and enable per entry. It sits between the 68000 bus and the memory/peripheral selects, and the table is loaded at boot from the PCB map data.

## Interface
- NUM_REGIONS, 24, number of table entries (1..32)
- ADDR_W, 24, CPU address width
- WAIT_W, 4, wait-state counter width
- TIMEOUT, 64, cycles before bus error on an unmapped access (>= 2)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_idx  in  5  entry index; writes with idx >= NUM_REGIONS ignored
- cfg_base  in  ADDR_W  region base address
- cfg_width  in  5  low address bits ignored in the compare (match when a>>width == base>>width)
- cfg_wait  in  WAIT_W  wait states before DTACK
- cfg_en  in  1  entry enable
- cpu_a  in  ADDR_W  CPU address
- cpu_as_n  in  1  address strobe, active low
- region_cs  out  NUM_REGIONS  registered one-hot chip selects
- hit_idx  out  5  index of the selected region
- dtack_n  out  1  data acknowledge, active low
- berr_n  out  1  bus error, active low
- multi_hit  out  1  sticky overlap flag (only with macro)

## Operation
- Table: NUM_REGIONS entries of {base, width, wait, en}.
  - A cfg_we write updates the entry on the next edge.
  - A write during an active cycle does not alter the latched selects of that cycle.
- Match per entry: en && (cpu_a >> width) == (cfg_base >> width). Any width >= ADDR_W matches every address.
- Priority: the lowest matching index wins, so region_cs is always one-hot or zero.
- FSM states: IDLE, WAIT, ACK, MISS.
- IDLE:
  - cpu_as_n sampled low with a hit: latch region_cs, hit_idx and cnt = wait.
  - Go to ACK if wait == 0, else WAIT.
  - No hit: go to MISS with cnt = 0.
- WAIT: cnt decrements each cycle; at cnt == 1 go to ACK.
- ACK: dtack_n low; hold until cpu_as_n sampled high.
- MISS: cnt increments each cycle; at TIMEOUT-1 go to a berr hold with berr_n low until cpu_as_n is high. region_cs stays 0 throughout.
- cpu_as_n sampled high in any non-IDLE state:
  - Next edge clears region_cs, hit_idx, dtack_n and berr_n, and returns to IDLE.
  - Aborts WAIT/MISS without DTACK or BERR.
- A new cycle is accepted only from IDLE. Back-to-back strobes therefore need as_n high for at least one sampled cycle.
- Reset:
  - Outputs: region_cs = 0, hit_idx = 0, dtack_n = 1, berr_n = 1, multi_hit = 0.
  - State: IDLE, cnt = 0, all entries en = 0 (base/width/wait = 0).
  - Reset mid-cycle takes effect on that edge; the pending cycle is dropped.

## Timing
- Edge T samples as_n low in IDLE.
- region_cs and hit_idx are valid after edge T+1 (latency 1).
- dtack_n low after edge T+1+W, where W = region wait; W = 0 gives DTACK together with CS.
- Miss: berr_n low after edge T+TIMEOUT.
- Release: as_n sampled high at edge R; all outputs return to idle values after edge R+1.
- cfg write at edge C affects decodes sampled at edge C+1 onward.
- A simultaneous cfg write and as_n fall at the same edge decode with the old entry.

## Configuration
- `DECODER_OVERLAP_CHECK_EN` defined:
  - multi_hit goes high one edge after any IDLE decode where two or more enabled entries match.
  - It stays high until reset.
  - Priority selection is unchanged.
- Undefined: the multi_hit port exists but is tied 0, and no overlap logic is built.

## Test plan
- Entry 0 = {base 0x000000, width 18, wait 0, en}; access 0x01234 -> region_cs = 0x000001 and dtack_n low at T+1; both clear at R+1.
- Entry 3 = {0x400000, width 1, wait 3}; access 0x400000 -> cs bit 3 at T+1, dtack_n low at T+4, hit_idx = 3.
- No entries enabled, TIMEOUT 64; access 0x123456 -> region_cs stays 0, berr_n low at T+64, high at R+1.
- Entries 2 and 5 both cover 0x080000 -> only cs bit 2 asserted; multi_hit = 1 when the macro is defined, 0 otherwise.
- Entry wait 7; as_n released at T+3 -> no DTACK ever; cs clears at T+4; next strobe decodes normally.
- reset asserted in WAIT -> next edge gives all outputs at reset values and table disabled; a subsequent access results in BERR.
